// File: rtl/gray_uart_tx_if.sv
// Sample-side bus of gray_uart_tx: converter pushes gray samples, gets back
// FIFO status (full, sticky overflow, occupancy).
interface gray_uart_tx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    i_gray;
  logic          i_valid;
  logic          o_full;
  logic          o_overflow;
  logic [LW-1:0] o_level;

  modport master (
    output i_gray,
    output i_valid,
    input  o_full,
    input  o_overflow,
    input  o_level
  );

  modport slave (
    input  i_gray,
    input  i_valid,
    output o_full,
    output o_overflow,
    output o_level
  );
endinterface

// File: rtl/gray_uart_tx.sv
// Gray-sample FIFO feeding an 8N1 UART transmitter (LSB first). Samples
// arriving while the FIFO is full are dropped and flagged via sticky overflow.
module gray_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  gray_uart_tx_if.slave  bus,
  output logic           o_tx,
  output logic           o_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          r_overflow;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  state_t        w_state_next;
  logic [BW-1:0] w_baud_next;
  logic [2:0]    w_bit_next;
  logic [7:0]    w_shift_next;
  logic          w_tx_next;
  logic          w_pop;
  logic          w_push;
  logic          w_full;

  // Full check uses start-of-cycle occupancy, so a same-cycle pop never rescues a push.
  assign w_full = (r_count == LEVEL_MAX);
  assign w_push = bus.i_valid && !w_full;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.i_gray;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.i_valid && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  // Line level is computed for the next state so o_tx comes straight from a flop.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_bit_next   = '0;
          w_tx_next    = 1'b0;
          w_state_next = START;
        end
      end
      START: begin
        if (r_baud == BAUD_MAX) begin
          w_baud_next  = '0;
          w_tx_next    = r_shift[0];
          w_state_next = DATA;
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      DATA: begin
        if (r_baud == BAUD_MAX) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = STOP;
          end else begin
            w_bit_next = r_bit + 3'd1;
            w_tx_next  = r_shift[1];
          end
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      STOP: begin
        if (r_baud == BAUD_MAX) begin
          w_baud_next  = '0;
          w_tx_next    = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      default: begin
        w_baud_next  = '0;
        w_tx_next    = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_tx           = r_tx;
  assign o_busy         = (r_state != IDLE) || (r_count != '0);
  assign bus.o_full     = w_full;
  assign bus.o_overflow = r_overflow;
  assign bus.o_level    = r_count;
endmodule

// File: tb/tb_gray_uart_tx.sv
// Directed + random bench for gray_uart_tx; a frame-level queue model predicts
// line level, occupancy and flags every cycle.
module tb_gray_uart_tx;
  localparam int C     = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * C;

  logic clk = 1'b0;
  logic rst;
  logic o_tx;
  logic o_busy;

  gray_uart_tx_if #(.FIFO_DEPTH(D)) bus ();

  gray_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_tx   (o_tx),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  byte unsigned m_q[$];
  int           m_rem;
  logic [9:0]   m_frame;
  logic         m_ovf;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_tx();
    if (m_rem == 0) return 1'b1;
    return m_frame[(FRAME - m_rem) / C];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rem   = 0;
    m_frame = '1;
    m_ovf   = 1'b0;
  endtask

  task automatic check_all();
    chk("tx",    16'(o_tx),           16'(m_tx()));
    chk("level", 16'(bus.o_level),    16'(m_q.size()));
    chk("full",  16'(bus.o_full),     16'(m_q.size() == D));
    chk("ovf",   16'(bus.o_overflow), 16'(m_ovf));
    chk("busy",  16'(o_busy),         16'((m_rem != 0) || (m_q.size() != 0)));
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input logic v, input logic [7:0] d);
    bit           pop;
    bit           acc;
    byte unsigned head;
    bus.i_valid = v;
    bus.i_gray  = d;
    @(posedge clk);
    pop = (m_rem == 0) && (m_q.size() > 0);
    acc = v && (m_q.size() < D);
    if (v && !acc) m_ovf = 1'b1;
    if (pop) begin
      head    = m_q.pop_front();
      m_frame = {1'b1, head, 1'b0};
      m_rem   = FRAME;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    if (acc) m_q.push_back(d);
    #1;
    bus.i_valid = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_rem != 0 || m_q.size() != 0) && guard < 2000) begin
      step(1'b0, 8'h00);
      guard++;
    end
    step(1'b0, 8'h00);
    chk("drain_bound", 16'(guard < 2000), 16'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_tx",    16'(o_tx),           16'd1);
    chk("rst_level", 16'(bus.o_level),    16'd0);
    chk("rst_busy",  16'(o_busy),         16'd0);
    chk("rst_full",  16'(bus.o_full),     16'd0);
    chk("rst_ovf",   16'(bus.o_overflow), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int  peak;
    int  guard;
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_gray  = 8'h00;
    model_reset();
    #12;
    apply_reset();

    // Single byte 0xA5: cycle 0 is the i_valid cycle.
    step(1'b1, 8'hA5);
    for (int t = 1; t < 46; t++) begin
      if (t == 1)  chk("single_level_c1", 16'(bus.o_level), 16'd1);
      if (t == 2)  chk("single_start_c2", 16'(o_tx), 16'd0);
      if (t == 2)  chk("single_level_c2", 16'(bus.o_level), 16'd0);
      if (t == 5)  chk("single_start_c5", 16'(o_tx), 16'd0);
      if (t == 6)  chk("single_bit0",     16'(o_tx), 16'd1);
      if (t == 10) chk("single_bit1",     16'(o_tx), 16'd0);
      if (t == 37) chk("single_bit7",     16'(o_tx), 16'd1);
      if (t == 38) chk("single_stop",     16'(o_tx), 16'd1);
      if (t == 41) chk("single_busy_c41", 16'(o_busy), 16'd1);
      if (t == 42) chk("single_busy_c42", 16'(o_busy), 16'd0);
      step(1'b0, 8'h00);
    end

    // Burst of three on consecutive cycles.
    apply_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    chk("burst_start0", 16'(o_tx), 16'd0);
    step(1'b1, 8'h3C);
    peak = 0;
    for (int t = 3; t < 130; t++) begin
      if (int'(bus.o_level) > peak) peak = int'(bus.o_level);
      if (t == 42) chk("burst_gap1",   16'(o_tx), 16'd1);
      if (t == 43) chk("burst_start1", 16'(o_tx), 16'd0);
      if (t == 83) chk("burst_gap2",   16'(o_tx), 16'd1);
      if (t == 84) chk("burst_start2", 16'(o_tx), 16'd0);
      step(1'b0, 8'h00);
    end
    chk("burst_peak", 16'(peak), 16'd2);
    drain();

    // Push on full in the very cycle the FSM pops.
    apply_reset();
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    step(1'b1, 8'h44);
    step(1'b1, 8'h55);
    chk("pf_level4", 16'(bus.o_level), 16'd4);
    guard = 0;
    while (!(m_rem == 0 && m_q.size() > 0) && guard < 200) begin
      step(1'b0, 8'h00);
      guard++;
    end
    chk("pf_wait_bound", 16'(guard < 200), 16'd1);
    chk("pf_full_pre", 16'(bus.o_full), 16'd1);
    step(1'b1, 8'h66);
    chk("pf_level3", 16'(bus.o_level), 16'd3);
    chk("pf_ovf",    16'(bus.o_overflow), 16'd1);
    drain();

    // Overflow with six pushes into a 4-deep FIFO.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(8'h10 + i));
      if (i == 4) chk("ovf_full_c5", 16'(bus.o_full), 16'd1);
      if (i == 4) chk("ovf_low_c5",  16'(bus.o_overflow), 16'd0);
      if (i == 5) chk("ovf_set_c6",  16'(bus.o_overflow), 16'd1);
    end
    drain();
    chk("ovf_sticky", 16'(bus.o_overflow), 16'd1);

    // Reset during DATA bit 3 with two bytes queued.
    apply_reset();
    step(1'b1, 8'hC3);
    step(1'b1, 8'h5A);
    step(1'b1, 8'h96);
    guard = 0;
    while (m_rem != FRAME - 4 * C - 1 && guard < 200) begin
      step(1'b0, 8'h00);
      guard++;
    end
    chk("mr_wait_bound", 16'(guard < 200), 16'd1);
    chk("mr_level_pre",  16'(bus.o_level), 16'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_tx",    16'(o_tx),        16'd1);
    chk("mr_level", 16'(bus.o_level), 16'd0);
    chk("mr_busy",  16'(o_busy),      16'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(60);

    // Pointer wrap: 40 paced bytes n*7.
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      step(1'b1, 8'(n * 7));
      idle(FRAME);
    end
    drain();
    chk("wrap_no_ovf", 16'(bus.o_overflow), 16'd0);

    // Random bursts.
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) == 0), 8'($urandom));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
